sad_disparity_ctrl: RTL and testbench
=====================================

Name: sad_disparity_ctrl

Overview:
Scheduler that sequences the block-SAD engine across a frame to produce one disparity per interior pixel.
- For each reference block centre (x,y), issues compare requests for disparities d = 0..MAX_DISP-1.
- Collects each SAD, tracks the running minimum and emits the winning disparity.
- Sits between the frame-level control and the SAD engine that reads buffer1 (left) and buffer2 (right).

Parameters:
CAMERA_HSIZE, 640, frame width in pixels
CAMERA_VSIZE, 480, frame height in pixels
MEAN_SIZE, 16, SAD value width in bits
BLOCK_SIZE, 5, block edge (odd); HALF = BLOCK_SIZE/2
MAX_DISP, 64, disparity candidates per pixel

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  reset, asynchronous, active-low
frame_start  in  1  one-cycle pulse; starts a frame scan when idle
busy  out  1  high from accepted frame_start until frame_done
req_valid  out  1  compare request to SAD engine
req_ready  in  1  engine accepts request
req_x  out  X_W  reference block centre column, X_W = $clog2(CAMERA_HSIZE)
req_y  out  Y_W  block centre row, Y_W = $clog2(CAMERA_VSIZE)
req_cmp_x  out  X_W  buffer2 block centre column = req_x - req_d
req_d  out  D_W  disparity under test, D_W = $clog2(MAX_DISP)
sad_valid  in  1  engine result strobe (one cycle)
sad_value  in  MEAN_SIZE  SAD for last accepted request
disp_valid  out  1  disparity result valid
disp_ready  in  1  downstream accepts result
disp_x  out  X_W  result column
disp_y  out  Y_W  result row
disp_value  out  D_W  winning disparity
frame_done  out  1  one-cycle pulse after last result accepted

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters and minimum cleared. Reset mid-frame abandons the scan, and no frame_done is produced.
- Scan order: y = HALF..VSIZE-1-HALF (outer loop), then x = HALF..HSIZE-1-HALF, then d = 0 upward.
- Border pixels are never requested or emitted.
- Candidate d is legal only while x - d >= HALF. Candidates per pixel: N = min(MAX_DISP, x - HALF + 1). Illegal d are skipped, not issued.
- FSM:
  - IDLE: frame_start -> ISSUE with x = y = HALF, d = 0, min = all-ones, best = 0.
  - ISSUE: req_valid = 1, fields stable until req_valid && req_ready; then -> WAIT.
  - WAIT: on sad_valid, if sad_value < min (strict, so ties keep the smaller d), update min and best. Then:
    - if d was the last legal candidate -> EMIT;
    - otherwise d+1 -> ISSUE.
  - EMIT: disp_valid = 1 with x, y, best held until disp_ready. On the handshake:
    - if more pixels remain, advance x (wrap to HALF, y+1), reset min/best -> ISSUE;
    - otherwise pulse frame_done -> IDLE.
- Exactly one request is outstanding at a time. sad_valid outside WAIT is ignored.
- frame_start while busy is ignored.
- Latency:
  - first req_valid 1 cycle after frame_start;
  - next req_valid 1 cycle after sad_valid;
  - disp_valid 1 cycle after the final sad_valid of a pixel.
- disp_ready low stalls the scan: no new request is issued while in EMIT.
- min register is MEAN_SIZE bits unsigned; SAD is unsigned, no saturation needed.

Optional Feature:
Macro SAD_CONF_EN.
- Defined:
  - also tracks the second-lowest SAD;
  - adds parameter CONF_THRESH (default 8) and output port disp_conf (1 bit, reset 0), valid with disp_valid;
  - disp_conf = 1 when (second_min - min) >= CONF_THRESH;
  - a pixel with N = 1 reports disp_conf = 0.
- Undefined: no second-minimum logic, no disp_conf port, and CONF_THRESH is unused.

Decomposition:
- Package sad_pkg:
  - state enum typedef (IDLE, ISSUE, WAIT, EMIT);
  - width helper functions for X_W / Y_W / D_W;
  - SAD_MAX constant (all-ones MEAN_SIZE).
- One sub-module, sad_min_tracker:
  - holds min, best and, with SAD_CONF_EN, the second minimum;
  - inputs: clear, sample strobe, value, d;
  - outputs: best, confidence.

Test Plan:
- Use HSIZE=8, VSIZE=5, BLOCK=3, MAX_DISP=4 unless stated.
- frame_start, engine returns sad = 10*|d-2|+1 -> each pixel emits disp_value = min(2, x-1); 18 results then one frame_done pulse.
- Pixel x=1: only d=0 is requested (req_cmp_x = 1) -> disp_value 0; pixel x=2 requests d = 0,1 only.
- Equal SAD 5 for all d -> disp_value 0 (tie keeps smallest d).
- Hold disp_ready low 20 cycles at the first result -> req_valid stays 0 and disp fields stay stable; release -> scan resumes next cycle.
- Assert rst_n low mid-WAIT, then frame_start -> outputs 0 during reset; scan restarts at (1,1), d=0; no stray frame_done.
- SAD_CONF_EN, CONF_THRESH=8: sads {20,5,9,30} -> disp_value 1, disp_conf 0; sads {20,5,14,30} -> disp_conf 1.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared types and helpers for the SAD disparity scheduler.
// Provides the FSM state enum, port-width helpers and the SAD ceiling.
package sad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        EMIT
    } state_t;

    localparam int SAD_W = 16;
    localparam logic [SAD_W-1:0] SAD_MAX = {SAD_W{1'b1}};

    // Widths never collapse to zero even for tiny frames.
    function automatic int x_w(input int hsize);
        return (hsize > 2) ? $clog2(hsize) : 1;
    endfunction

    function automatic int y_w(input int vsize);
        return (vsize > 2) ? $clog2(vsize) : 1;
    endfunction

    function automatic int d_w(input int max_disp);
        return (max_disp > 2) ? $clog2(max_disp) : 1;
    endfunction

endpackage

// File: rtl/sad_disparity_ctrl_min_tracker.sv
// Running-minimum tracker for one pixel's disparity candidates.
// Ports: clk, rst_n, clear (start new pixel), sample (value valid),
//   value (SAD), d (candidate), best (winning d); with SAD_CONF_EN
//   also conf (second-min minus min reaches CONF_THRESH).
module sad_min_tracker
    import sad_pkg::*;
#(
    parameter int MEAN_SIZE = 16,
    parameter int D_W       = 6
`ifdef SAD_CONF_EN
    ,
    parameter int CONF_THRESH = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 sample,
    input  logic [MEAN_SIZE-1:0] value,
    input  logic [D_W-1:0]       d,
    output logic [D_W-1:0]       best
`ifdef SAD_CONF_EN
    ,
    output logic                 conf
`endif
);

    localparam logic [MEAN_SIZE-1:0] MIN_INIT = {MEAN_SIZE{1'b1}};

    logic [MEAN_SIZE-1:0] min_q;
    logic [D_W-1:0]       best_q;

    // Strict less-than keeps the earliest (smallest) d on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q  <= MIN_INIT;
            best_q <= '0;
        end else if (clear) begin
            min_q  <= MIN_INIT;
            best_q <= '0;
        end else if (sample && (value < min_q)) begin
            min_q  <= value;
            best_q <= d;
        end
    end

    assign best = best_q;

`ifdef SAD_CONF_EN
    logic [MEAN_SIZE-1:0] sec_q;
    logic                 seen_q;
    logic                 multi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q   <= MIN_INIT;
            seen_q  <= 1'b0;
            multi_q <= 1'b0;
        end else if (clear) begin
            sec_q   <= MIN_INIT;
            seen_q  <= 1'b0;
            multi_q <= 1'b0;
        end else if (sample) begin
            seen_q  <= 1'b1;
            multi_q <= multi_q | seen_q;
            if (value < min_q) begin
                sec_q <= min_q;
            end else if (value < sec_q) begin
                sec_q <= value;
            end
        end
    end

    // A single candidate has no runner-up, so it is never confident.
    assign conf = multi_q &&
        ((sec_q - min_q) >= MEAN_SIZE'(CONF_THRESH));
`endif

endmodule

// File: rtl/sad_disparity_ctrl.sv
// Frame scheduler driving the block-SAD engine, one disparity per pixel.
// Ports: frame_start/busy/frame_done (frame control), req_* (engine
//   request handshake), sad_valid/sad_value (engine result),
//   disp_* (result handshake); disp_conf only with SAD_CONF_EN.
module sad_disparity_ctrl
    import sad_pkg::*;
#(
    parameter int CAMERA_HSIZE = 640,
    parameter int CAMERA_VSIZE = 480,
    parameter int MEAN_SIZE    = 16,
    parameter int BLOCK_SIZE   = 5,
    parameter int MAX_DISP     = 64,
`ifdef SAD_CONF_EN
    parameter int CONF_THRESH  = 8,
`endif
    localparam int X_W = x_w(CAMERA_HSIZE),
    localparam int Y_W = y_w(CAMERA_VSIZE),
    localparam int D_W = d_w(MAX_DISP)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    output logic                 busy,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic [X_W-1:0]       req_x,
    output logic [Y_W-1:0]       req_y,
    output logic [X_W-1:0]       req_cmp_x,
    output logic [D_W-1:0]       req_d,
    input  logic                 sad_valid,
    input  logic [MEAN_SIZE-1:0] sad_value,
    output logic                 disp_valid,
    input  logic                 disp_ready,
    output logic [X_W-1:0]       disp_x,
    output logic [Y_W-1:0]       disp_y,
    output logic [D_W-1:0]       disp_value,
`ifdef SAD_CONF_EN
    output logic                 disp_conf,
`endif
    output logic                 frame_done
);

    localparam int HALF = BLOCK_SIZE / 2;
    localparam int X_LO = HALF;
    localparam int X_HI = CAMERA_HSIZE - 1 - HALF;
    localparam int Y_LO = HALF;
    localparam int Y_HI = CAMERA_VSIZE - 1 - HALF;
    localparam int XD_W = X_W + 1;

    state_t state_q, state_d;

    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic [D_W-1:0] d_q;
    logic           done_q;

    logic start_scan;
    logic next_d;
    logic next_px;
    logic fin;
    logic trk_clear;
    logic trk_sample;
    logic last_d;
    logic last_px;

    logic [XD_W-1:0] x_minus_d;
    logic [D_W-1:0]  best;

    // Extra bit keeps x - d from wrapping when checking the left border.
    assign x_minus_d = {1'b0, x_q} - XD_W'(d_q);
    assign last_d    = (x_minus_d == XD_W'(HALF)) ||
                       (d_q == D_W'(MAX_DISP - 1));
    assign last_px   = (x_q == X_W'(X_HI)) && (y_q == Y_W'(Y_HI));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_scan = 1'b0;
        next_d     = 1'b0;
        next_px    = 1'b0;
        fin        = 1'b0;
        trk_clear  = 1'b0;
        trk_sample = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    start_scan = 1'b1;
                    trk_clear  = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (sad_valid) begin
                    trk_sample = 1'b1;
                    if (last_d) begin
                        state_d = EMIT;
                    end else begin
                        next_d  = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            EMIT: begin
                if (disp_ready) begin
                    if (last_px) begin
                        fin     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        next_px   = 1'b1;
                        trk_clear = 1'b1;
                        state_d   = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            d_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= fin;
            if (start_scan) begin
                x_q <= X_W'(X_LO);
                y_q <= Y_W'(Y_LO);
                d_q <= '0;
            end else if (next_d) begin
                d_q <= d_q + D_W'(1);
            end else if (next_px) begin
                d_q <= '0;
                if (x_q == X_W'(X_HI)) begin
                    x_q <= X_W'(X_LO);
                    y_q <= y_q + Y_W'(1);
                end else begin
                    x_q <= x_q + X_W'(1);
                end
            end
        end
    end

    sad_min_tracker #(
        .MEAN_SIZE   (MEAN_SIZE),
`ifdef SAD_CONF_EN
        .CONF_THRESH (CONF_THRESH),
`endif
        .D_W         (D_W)
    ) u_trk (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (trk_clear),
        .sample (trk_sample),
        .value  (sad_value),
        .d      (d_q),
`ifdef SAD_CONF_EN
        .conf   (disp_conf),
`endif
        .best   (best)
    );

    assign busy       = (state_q != IDLE);
    assign req_valid  = (state_q == ISSUE);
    assign req_x      = x_q;
    assign req_y      = y_q;
    assign req_d      = d_q;
    assign req_cmp_x  = x_q - X_W'(d_q);
    assign disp_valid = (state_q == EMIT);
    assign disp_x     = x_q;
    assign disp_y     = y_q;
    assign disp_value = best;
    assign frame_done = done_q;

endmodule

// File: tb/tb_sad_disparity_ctrl.sv
// Scoreboard bench for sad_disparity_ctrl on an 8x5 frame, 3x3 block,
// four disparities; build with +define+SAD_CONF_EN to check disp_conf.
`timescale 1ns/1ps
module tb_sad_disparity_ctrl;

    localparam int H    = 8;
    localparam int V    = 5;
    localparam int B    = 3;
    localparam int MD   = 4;
    localparam int MS   = 16;
    localparam int HALF = B / 2;
    localparam int CT   = 8;
    localparam int X_W  = 3;
    localparam int Y_W  = 3;
    localparam int D_W  = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           frame_start = 1'b0;
    logic           busy;
    logic           req_valid;
    logic           req_ready;
    logic [X_W-1:0] req_x;
    logic [Y_W-1:0] req_y;
    logic [X_W-1:0] req_cmp_x;
    logic [D_W-1:0] req_d;
    logic           sad_valid;
    logic [MS-1:0]  sad_value;
    logic           disp_valid;
    logic           disp_ready;
    logic [X_W-1:0] disp_x;
    logic [Y_W-1:0] disp_y;
    logic [D_W-1:0] disp_value;
    logic           frame_done;
`ifdef SAD_CONF_EN
    logic           disp_conf;
`endif

    always #5 clk = ~clk;

    sad_disparity_ctrl #(
        .CAMERA_HSIZE (H),
        .CAMERA_VSIZE (V),
        .MEAN_SIZE    (MS),
        .BLOCK_SIZE   (B),
`ifdef SAD_CONF_EN
        .CONF_THRESH  (CT),
`endif
        .MAX_DISP     (MD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .busy        (busy),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_cmp_x   (req_cmp_x),
        .req_d       (req_d),
        .sad_valid   (sad_valid),
        .sad_value   (sad_value),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_x      (disp_x),
        .disp_y      (disp_y),
        .disp_value  (disp_value),
`ifdef SAD_CONF_EN
        .disp_conf   (disp_conf),
`endif
        .frame_done  (frame_done)
    );

    typedef struct {
        int x;
        int y;
        int d;
        int c;
    } req_t;

    typedef struct {
        int x;
        int y;
        int v;
        int conf;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int cur_mode = 0;
    int rdy_mode = 0;
    int slow     = 0;
    int unsigned seed = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic int unsigned sad_fn(int m, int x, int y, int d);
        int unsigned h;
        int unsigned ta[4];
        int unsigned tb[4];
        ta = '{20, 5, 9, 30};
        tb = '{20, 5, 14, 30};
        h = (x * 131 + y * 71 + d * 29 + seed) * 40503;
        case (m)
            0: return 10 * ((d > 2) ? d - 2 : 2 - d) + 1;
            1: return 5;
            2: return (h >> 7) % 50;
            3: return ta[d];
            4: return tb[d];
            default: return (h >> 5) % 65536;
        endcase
    endfunction

    // Reference: scan every interior pixel, try each legal d,
    // pick the first argmin, rank the sorted SADs for confidence.
    task automatic build_exp(int m);
        int n;
        int bv;
        int bd;
        int v;
        int s[$];
        res_t r;
        for (int y = HALF; y <= V - 1 - HALF; y++) begin
            for (int x = HALF; x <= H - 1 - HALF; x++) begin
                n = (MD < x - HALF + 1) ? MD : x - HALF + 1;
                s.delete();
                bv = 0;
                bd = 0;
                for (int d = 0; d < n; d++) begin
                    v = int'(sad_fn(m, x, y, d));
                    req_q.push_back('{x, y, d, x - d});
                    s.push_back(v);
                    if (d == 0 || v < bv) begin
                        bv = v;
                        bd = d;
                    end
                end
                s.sort();
                r.x = x;
                r.y = y;
                r.v = bd;
                r.conf = (n > 1 && (s[1] - s[0]) >= CT) ? 1 : 0;
                res_q.push_back(r);
            end
        end
    endtask

    // SAD engine model: random ready, random response latency,
    // and junk strobes whenever no request is outstanding.
    initial begin
        int pend;
        int cnt;
        logic [MS-1:0] val;
        pend = 0;
        cnt = 0;
        val = '0;
        req_ready = 1'b0;
        sad_valid = 1'b0;
        sad_value = '0;
        disp_ready = 1'b0;
        forever begin
            @(negedge clk);
            sad_valid = 1'b0;
            if (!rst_n) begin
                pend = 0;
                req_ready = 1'b0;
                disp_ready = 1'b0;
            end else begin
                if (pend != 0) begin
                    if (cnt == 0) begin
                        sad_valid = 1'b1;
                        sad_value = val;
                        pend = 0;
                    end else begin
                        cnt--;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    sad_valid = 1'b1;
                    sad_value = '0;
                end
                req_ready = ($urandom_range(0, 2) != 0);
                if (req_valid && req_ready) begin
                    pend = 1;
                    cnt = (slow != 0) ? 6 : $urandom_range(0, 2);
                    val = MS'(sad_fn(cur_mode, int'(req_x),
                                     int'(req_y), int'(req_d)));
                end
                case (rdy_mode)
                    1: disp_ready = 1'b0;
                    2: disp_ready = 1'b1;
                    default: disp_ready = ($urandom_range(0, 3) != 0);
                endcase
            end
        end
    end

    // Monitor: pops expectations on every handshake.
    initial begin
        req_t r;
        res_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (req_valid && req_ready) begin
                    if (req_q.size() == 0) begin
                        chk("req_unexpected", 1, 0);
                    end else begin
                        r = req_q.pop_front();
                        chk("req_x", int'(req_x), r.x);
                        chk("req_y", int'(req_y), r.y);
                        chk("req_d", int'(req_d), r.d);
                        chk("req_cmp_x", int'(req_cmp_x), r.c);
                    end
                end
                if (disp_valid && disp_ready) begin
                    if (res_q.size() == 0) begin
                        chk("disp_unexpected", 1, 0);
                    end else begin
                        e = res_q.pop_front();
                        chk("disp_x", int'(disp_x), e.x);
                        chk("disp_y", int'(disp_y), e.y);
                        chk("disp_value", int'(disp_value), e.v);
`ifdef SAD_CONF_EN
                        chk("disp_conf", int'(disp_conf), e.conf);
`endif
                    end
                end
                if (frame_done) begin
                    done_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_req_valid", int'(req_valid), 1);
    endtask

    task automatic run_frame(int m, int stall, int poke);
        int base;
        int sx;
        int sy;
        int sv;
        int ok;
        int got;
        build_exp(m);
        cur_mode = m;
        base = done_cnt;
        rdy_mode = (stall != 0) ? 1 : 0;
        start_frame();
        if (stall != 0) begin
            got = 0;
            for (int i = 0; i < 500 && got == 0; i++) begin
                if (disp_valid) got = 1;
                else tick();
            end
            chk("stall_reach_emit", got, 1);
            sx = int'(disp_x);
            sy = int'(disp_y);
            sv = int'(disp_value);
            for (int i = 0; i < 20; i++) begin
                tick();
                ok = (!req_valid && disp_valid && int'(disp_x) == sx &&
                      int'(disp_y) == sy && int'(disp_value) == sv) ? 1 : 0;
                chk("stall_hold", ok, 1);
            end
            rdy_mode = 2;
            tick();
            tick();
            chk("stall_resume_req", int'(req_valid), 1);
            rdy_mode = 0;
        end
        got = 0;
        for (int i = 0; i < 4000 && got == 0; i++) begin
            if (poke != 0 && i == 40) frame_start = 1'b1;
            if (poke != 0 && i == 41) frame_start = 1'b0;
            if (done_cnt > base) got = 1;
            else tick();
        end
        frame_start = 1'b0;
        chk("frame_done_seen", got, 1);
        tick();
        tick();
        chk("frame_done_once", done_cnt - base, 1);
        chk("req_queue_drained", req_q.size(), 0);
        chk("res_queue_drained", res_q.size(), 0);
        chk("idle_busy", int'(busy), 0);
        req_q.delete();
        res_q.delete();
    endtask

    task automatic reset_mid_wait();
        int got;
        int base;
        int outs;
        build_exp(0);
        cur_mode = 0;
        slow = 1;
        start_frame();
        got = 0;
        for (int i = 0; i < 200 && got == 0; i++) begin
            if (req_valid && req_ready) got = 1;
            else tick();
        end
        chk("reset_reach_wait", got, 1);
        tick();
        base = done_cnt;
        rst_n = 1'b0;
        #1;
        outs = int'({req_valid, req_x, req_y, req_d, req_cmp_x,
                     disp_valid, disp_x, disp_y, disp_value,
                     busy, frame_done});
`ifdef SAD_CONF_EN
        outs = outs | int'(disp_conf);
`endif
        chk("reset_mid_outputs", outs, 0);
        req_q.delete();
        res_q.delete();
        tick();
        tick();
        tick();
        rst_n = 1'b1;
        slow = 0;
        tick();
        tick();
        chk("no_stray_done", done_cnt - base, 0);
        chk("post_reset_idle", int'(busy), 0);
    endtask

    initial begin
        int outs;
        rst_n = 1'b0;
        tick();
        tick();
        outs = int'({req_valid, req_x, req_y, req_d, req_cmp_x,
                     disp_valid, disp_x, disp_y, disp_value,
                     busy, frame_done});
`ifdef SAD_CONF_EN
        outs = outs | int'(disp_conf);
`endif
        chk("reset_outputs", outs, 0);
        rst_n = 1'b1;
        tick();
        chk("reset_idle", int'(busy), 0);

        run_frame(0, 0, 1);
        run_frame(1, 0, 0);
        run_frame(0, 1, 0);
        reset_mid_wait();
        run_frame(0, 0, 0);
        run_frame(3, 0, 0);
        run_frame(4, 0, 0);
        for (int k = 0; k < 3; k++) begin
            seed = $urandom;
            run_frame(2 + 3 * (k % 2), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
